// File: rtl/cam_capture_gen.sv
// Camera byte-bus capture into a frame buffer write port.
// Supports RGB565 / YUV422-luma / RAW8 assembly, optional 2:1 decimation and per-frame geometry checks.
module cam_capture_gen #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              decim,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    output logic              we,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              line_err,
    output logic              frame_err
);

    localparam int BC_W      = $clog2(2 * H_ACTIVE + 2) + 1;
    localparam int AMAX_FULL = H_ACTIVE * V_ACTIVE - 1;
    localparam int AMAX_DEC  = (H_ACTIVE / 2) * (V_ACTIVE / 2) - 1;

    // IDLE: wait vsync high | SYNC: wait vsync fall | ACTIVE: capture | DONE: close frame
    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DONE} state_t;
    state_t state;

    logic            vs_s, hr_s, vs_q, hr_q;
    logic [7:0]      d_s, b0;
    logic [1:0]      cap_mode;
    logic            cap_decim;
    logic [BC_W-1:0] bcnt;
    logic [8:0]      line_cnt;

    always_ff @(negedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s <= 1'b0;
            hr_s <= 1'b0;
            d_s  <= 8'h00;
        end else begin
            vs_s <= vsync;
            hr_s <= href;
            d_s  <= d;
        end
    end

    logic              vs_rise, vs_fall, hr_fall, byte_ok, raw8, pix_done;
    logic              in_line, keep, in_frame;
    logic [BC_W-1:0]   pix_idx, exp_bytes;
    logic [ADDR_W-1:0] addr_max;
    logic [15:0]       pix_val;

    always_comb begin
        vs_rise   = vs_s & ~vs_q;
        vs_fall   = vs_q & ~vs_s;
        hr_fall   = hr_q & ~hr_s;
        byte_ok   = hr_s & ~vs_s;
        raw8      = (cap_mode == 2'd2);
        pix_done  = raw8 | bcnt[0];
        pix_idx   = raw8 ? bcnt : {1'b0, bcnt[BC_W-1:1]};
        exp_bytes = raw8 ? BC_W'(H_ACTIVE) : BC_W'(2 * H_ACTIVE);
        in_line   = pix_idx < BC_W'(H_ACTIVE);
        keep      = ~cap_decim | (~pix_idx[0] & ~line_cnt[0]);
        in_frame  = line_cnt < 9'(V_ACTIVE);
        addr_max  = cap_decim ? ADDR_W'(AMAX_DEC) : ADDR_W'(AMAX_FULL);
        pix_val   = (cap_mode == 2'd0) ? {b0, d_s} : {8'h00, d_s};
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vs_q        <= 1'b0;
            hr_q        <= 1'b0;
            b0          <= 8'h00;
            cap_mode    <= 2'd0;
            cap_decim   <= 1'b0;
            bcnt        <= '0;
            line_cnt    <= '0;
            addr        <= '0;
            dout        <= '0;
            we          <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'h00;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            vs_q       <= vs_s;
            hr_q       <= hr_s;
            we         <= 1'b0;
            frame_done <= 1'b0;
            // address advances the cycle after each write strobe
            if (we && addr != addr_max)
                addr <= addr + 1'b1;

            case (state)
                IDLE: if (vs_s) state <= SYNC;
                SYNC: begin
                    if (vs_fall) begin
                        if (enable) begin
                            cap_mode  <= (mode == 2'd3) ? 2'd0 : mode;
                            cap_decim <= decim;
                            addr      <= '0;
                            bcnt      <= '0;
                            line_cnt  <= '0;
                            line_err  <= 1'b0;
                            frame_err <= 1'b0;
                            busy      <= 1'b1;
                            state     <= ACTIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ACTIVE: begin
                    if (byte_ok) begin
                        if (!bcnt[0]) b0 <= d_s;
                        if (bcnt != '1) bcnt <= bcnt + 1'b1;
                        if (pix_done && in_line && keep && in_frame) begin
                            we   <= 1'b1;
                            dout <= DATA_W'(pix_val);
                        end
                    end
                    // line-end bookkeeping precedes a coincident frame end
                    if (hr_fall) begin
                        if (bcnt != exp_bytes) line_err <= 1'b1;
                        bcnt <= '0;
                        if (line_cnt != 9'h1FF) line_cnt <= line_cnt + 1'b1;
                    end
                    if (vs_rise) state <= DONE;
                end
                DONE: begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 1'b1;
                    if (line_cnt != 9'(V_ACTIVE)) frame_err <= 1'b1;
                    busy        <= 1'b0;
                    state       <= SYNC;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_gen.sv
// Directed bench for cam_capture_gen on a small 8x4 geometry.
// Frame-level vector table plus hand-written enable and reset sequences.
module tb_cam_capture_gen;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 6;
    localparam int DW = 16;

    logic          pclk = 1'b0, rst_n = 1'b0, enable = 1'b0, decim = 1'b0;
    logic          vsync = 1'b0, href = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [7:0]    d = 8'h00;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          we, busy, frame_done, line_err, frame_err;
    logic [7:0]    frame_count;

    cam_capture_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW)) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .mode(mode), .decim(decim),
        .vsync(vsync), .href(href), .d(d), .addr(addr), .dout(dout), .we(we),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .line_err(line_err), .frame_err(frame_err));

    always #5 pclk = ~pclk;

    int total = 0;
    int bad = 0;
    logic [AW+DW-1:0] got_q[$];
    logic [AW+DW-1:0] exp_q[$];
    int fd_seen = 0;
    int len_a[0:7];
    logic busy_mid;

    always @(negedge pclk) begin
        if (we) got_q.push_back({addr, dout});
        if (frame_done) fd_seen++;
    end

    typedef struct {
        int mode; int decim; int pat; int nl;
        int l1; int len1; int l2; int len2;
        int exp_wr; int lerr; int ferr;
    } vec_t;
    vec_t tab[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input int pat, input int l, input int i);
        int v;
        if (pat == 0) v = l * 16 + i;
        else if (i % 2 == 0) v = 8'h80;
        else v = 8'h10 + l * H + i / 2;
        return 8'(v);
    endfunction

    task automatic set_lens(input int def);
        for (int l = 0; l < 8; l++) len_a[l] = def;
    endtask

    task automatic send_bytes(input int pat, input int l, input int from, input int to);
        for (int i = from; i < to; i++) begin
            href = 1'b1;
            d = byte_of(pat, l, i);
            tick();
        end
    endtask

    task automatic send_line(input int pat, input int l, input int len);
        send_bytes(pat, l, 0, len);
        href = 1'b0;
        d = 8'h00;
        repeat (3) tick();
    endtask

    task automatic run_frame(input int pat, input int nl, input int en_line, input logic en_val);
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        for (int l = 0; l < nl; l++) begin
            if (l == en_line) enable = en_val;
            send_line(pat, l, len_a[l]);
            if (l == 0) busy_mid = busy;
        end
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic build_model(input int md, input int dc, input int pat, input int nl);
        int m, bpp, a, amax, npx, val;
        m = (md == 3) ? 0 : md;
        bpp = (m == 2) ? 1 : 2;
        a = 0;
        amax = (H >> dc) * (V >> dc) - 1;
        exp_q.delete();
        for (int l = 0; l < nl; l++) begin
            npx = len_a[l] / bpp;
            if (npx > H) npx = H;
            for (int p = 0; p < npx; p++) begin
                if (l < V && (dc == 0 || (p % 2 == 0 && l % 2 == 0))) begin
                    if (m == 0) val = {byte_of(pat, l, 2 * p), byte_of(pat, l, 2 * p + 1)};
                    else if (m == 1) val = byte_of(pat, l, 2 * p + 1);
                    else val = byte_of(pat, l, p);
                    exp_q.push_back({AW'(a), DW'(val)});
                    if (a < amax) a++;
                end
            end
        end
    endtask

    task automatic cmp_writes(input string tag, input int base, input int exp_wr);
        int n;
        n = got_q.size() - base;
        chk({tag, " wr_count"}, n, exp_wr);
        chk({tag, " model_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            chk({tag, " wr"}, got_q[base + i], exp_q[i]);
    endtask

    initial begin
        int base, fd0, fc_exp;
        tab = '{
            '{0, 0, 0, 4, -1,  0, -1,  0, 32, 0, 0},
            '{2, 1, 0, 4, -1,  0, -1,  0,  8, 0, 0},
            '{1, 0, 1, 4, -1,  0, -1,  0, 32, 0, 0},
            '{0, 0, 0, 4,  1, 14,  2, 18, 31, 1, 0},
            '{0, 0, 0, 3, -1,  0, -1,  0, 24, 0, 1},
            '{3, 1, 0, 4, -1,  0, -1,  0,  8, 0, 0},
            '{0, 0, 0, 5, -1,  0, -1,  0, 32, 0, 1},
            '{1, 0, 1, 4,  0, 15, -1,  0, 31, 1, 0},
            '{2, 0, 0, 4, -1,  0, -1,  0, 32, 0, 0}
        };
        fc_exp = 0;
        repeat (3) tick();
        chk("rst addr", addr, 0);
        chk("rst dout", dout, 0);
        chk("rst we", we, 0);
        chk("rst busy", busy, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst frame_count", frame_count, 0);
        chk("rst errs", {line_err, frame_err}, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (2) tick();

        for (int k = 0; k < 9; k++) begin
            mode = 2'(tab[k].mode);
            decim = tab[k].decim[0];
            set_lens((tab[k].mode == 2) ? H : 2 * H);
            if (tab[k].l1 >= 0) len_a[tab[k].l1] = tab[k].len1;
            if (tab[k].l2 >= 0) len_a[tab[k].l2] = tab[k].len2;
            build_model(tab[k].mode, tab[k].decim, tab[k].pat, tab[k].nl);
            base = got_q.size();
            fd0 = fd_seen;
            run_frame(tab[k].pat, tab[k].nl, -1, 1'b1);
            fc_exp = (fc_exp + 1) & 255;
            cmp_writes($sformatf("vec%0d", k), base, tab[k].exp_wr);
            chk($sformatf("vec%0d busy_mid", k), busy_mid, 1);
            chk($sformatf("vec%0d busy_end", k), busy, 0);
            chk($sformatf("vec%0d frame_done", k), fd_seen - fd0, 1);
            chk($sformatf("vec%0d frame_count", k), frame_count, fc_exp);
            chk($sformatf("vec%0d line_err", k), line_err, tab[k].lerr);
            chk($sformatf("vec%0d frame_err", k), frame_err, tab[k].ferr);
        end

        // enable raised mid-frame: nothing until the next frame start
        mode = 2'd0; decim = 1'b0; set_lens(2 * H);
        enable = 1'b0;
        base = got_q.size(); fd0 = fd_seen;
        run_frame(0, 4, 1, 1'b1);
        chk("en_rise wr_count", got_q.size() - base, 0);
        chk("en_rise frame_done", fd_seen - fd0, 0);
        chk("en_rise frame_count", frame_count, fc_exp);
        build_model(0, 0, 0, 4);
        base = got_q.size(); fd0 = fd_seen;
        run_frame(0, 4, -1, 1'b1);
        fc_exp++;
        cmp_writes("en_next", base, 32);
        chk("en_next frame_count", frame_count, fc_exp);

        // enable dropped mid-frame: this frame completes, the next is skipped
        base = got_q.size(); fd0 = fd_seen;
        run_frame(0, 4, 1, 1'b0);
        fc_exp++;
        cmp_writes("en_drop", base, 32);
        chk("en_drop frame_done", fd_seen - fd0, 1);
        base = got_q.size(); fd0 = fd_seen;
        run_frame(0, 4, -1, 1'b0);
        chk("en_off wr_count", got_q.size() - base, 0);
        chk("en_off frame_done", fd_seen - fd0, 0);
        chk("en_off frame_count", frame_count, fc_exp);

        // reset mid-line during a capture
        enable = 1'b1;
        vsync = 1'b1; repeat (3) tick();
        vsync = 1'b0; repeat (2) tick();
        send_line(0, 0, 16);
        send_bytes(0, 1, 0, 5);
        chk("pre_rst busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst addr", addr, 0);
        chk("mid_rst dout", dout, 0);
        chk("mid_rst we", we, 0);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst frame_count", frame_count, 0);
        chk("mid_rst errs", {frame_done, line_err, frame_err}, 0);
        @(posedge pclk); #1;
        rst_n = 1'b1;
        base = got_q.size(); fd0 = fd_seen;
        send_bytes(0, 1, 5, 16);
        href = 1'b0; repeat (3) tick();
        send_line(0, 2, 16);
        send_line(0, 3, 16);
        vsync = 1'b1; repeat (4) tick();
        chk("post_rst wr_count", got_q.size() - base, 0);
        chk("post_rst frame_done", fd_seen - fd0, 0);
        build_model(0, 0, 0, 4);
        base = got_q.size();
        run_frame(0, 4, -1, 1'b1);
        cmp_writes("resume", base, 32);
        if (got_q.size() > base) chk("resume first addr", got_q[base][AW+DW-1:DW], 0);
        else chk("resume first addr present", 0, 1);
        chk("resume frame_count", frame_count, 1);
        chk("resume errs", {line_err, frame_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
